// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle unsigned restoring divider built around one shared subtractor.
// A start request in IDLE latches the operands. Each RUN cycle then retires
// one quotient bit, MSB first. After WIDTH cycles the block spends one cycle
// in DONE with a completion pulse.
//
// Division by zero skips the iterations entirely. It returns
//    quotient  = all ones
//    remainder = dividend
//    div_by_zero = 1
// and goes straight to DONE.
//
// Ports
//    clk          rising-edge clock
//    reset        asynchronous, active-high reset; aborts any operation
//    start        request, sampled only in IDLE
//    dividend     unsigned numerator, sampled with start
//    divisor      unsigned denominator, sampled with start
//    busy         high while in RUN or DONE
//    done         one-cycle completion pulse (high exactly in DONE)
//    quotient     quotient result register
//    remainder    remainder result register
//    div_by_zero  set when the last accepted divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // The counter must be able to hold the value WIDTH itself.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] quo_reg,   quo_next;
   logic [WIDTH-1:0] rem_reg,   rem_next;
   logic [WIDTH-1:0] dsr_reg,   dsr_next;
   logic [CW-1:0]    cnt_reg,   cnt_next;
   logic             dbz_reg,   dbz_next;

   // ------------------------------------------------------------------
   // Iteration datapath
   // ------------------------------------------------------------------
   // The quotient register starts out holding the dividend. Each cycle
   // its MSB is shifted into the partial remainder, which makes the
   // partial remainder WIDTH+1 bits wide.
   logic [WIDTH:0]   shift_rem;
   logic [WIDTH-1:0] shift_quo;
   logic [WIDTH:0]   trial;
   logic             borrow;

   assign shift_rem = {rem_reg, quo_reg[WIDTH-1]};
   assign shift_quo = {quo_reg[WIDTH-2:0], 1'b0};

   // The remainder is always below the divisor, so shift_rem < 2*divisor.
   // A WIDTH+1 bit subtraction is therefore enough:
   //    - no borrow: the difference is < divisor and its top bit is 0
   //    - borrow:    the wrapped result always has its top bit set
   assign trial  = shift_rem - {1'b0, dsr_reg};
   assign borrow = trial[WIDTH];

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         quo_reg   <= '0;
         rem_reg   <= '0;
         dsr_reg   <= '0;
         cnt_reg   <= '0;
         dbz_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         quo_reg   <= quo_next;
         rem_reg   <= rem_next;
         dsr_reg   <= dsr_next;
         cnt_reg   <= cnt_next;
         dbz_reg   <= dbz_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      quo_next   = quo_reg;
      rem_next   = rem_reg;
      dsr_next   = dsr_reg;
      cnt_next   = cnt_reg;
      dbz_next   = dbz_reg;

      unique case (state_reg)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quo_next   = '1;
                  rem_next   = dividend;
                  dsr_next   = divisor;
                  dbz_next   = 1'b1;
                  state_next = S_DONE;
               end else begin
                  quo_next   = dividend;
                  rem_next   = '0;
                  dsr_next   = divisor;
                  cnt_next   = CNT_LOAD;
                  dbz_next   = 1'b0;
                  state_next = S_RUN;
               end
            end
         end

         S_RUN: begin
            if (!borrow) begin
               rem_next = trial[WIDTH-1:0];
               quo_next = shift_quo | {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
               rem_next = shift_rem[WIDTH-1:0];
               quo_next = shift_quo;
            end
            cnt_next = cnt_reg - CNT_ONE;
            // The last iteration is the one that takes the counter to zero.
            if (cnt_reg == CNT_ONE) begin
               state_next = S_DONE;
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The status outputs are decoded from the state register only, so a
   // change on start cannot reach them combinationally.
   assign busy        = (state_reg != S_IDLE);
   assign done        = (state_reg == S_DONE);
   assign quotient    = quo_reg;
   assign remainder   = rem_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed and random checks of seq_divider at WIDTH=64.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int W = 64;
   localparam logic [W-1:0] ONES = '1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int tests_run    = 0;
   int tests_failed = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one start pulse, then waits for done.
   // lat counts the clock edges from the sampling edge E0 to entry into DONE:
   //    normal divide  -> W
   //    divide by zero -> 0
   //    timeout        -> -1
   // On return the bench sits on the negedge where done is high.
   // The operands are scrambled after sampling, which must have no effect.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = ~a;
      divisor  = '0;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      tests_run++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: busy/done/dbz=%b required 000",
                  {busy, done, div_by_zero});
      end
      tests_run++;
      if (quotient !== '0 || remainder !== '0) begin
         tests_failed++;
         $display("FAIL reset_results: q=%h r=%h required 0 0", quotient, remainder);
      end
      @(negedge clk);
      reset = 1'b0;
      $display("[TB] reset released");
   endtask

   task automatic test_normal;
      int lat;
      run_op(64'd100, 64'd7, lat);
      $display("[TB] 100/7 -> q=%0d r=%0d dbz=%b lat=%0d",
               quotient, remainder, div_by_zero, lat);
      tests_run++;
      if (lat !== W) begin
         tests_failed++;
         $display("FAIL normal_latency: got %0d required %0d", lat, W);
      end
      tests_run++;
      if (quotient !== 64'd14 || remainder !== 64'd2 || div_by_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL normal_result: q=%0d r=%0d dbz=%b required 14 2 0",
                  quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL normal_pulse: done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_div_by_zero;
      int lat;
      run_op(64'h1234, 64'd0, lat);
      $display("[TB] 0x1234/0 -> q=%h r=%h dbz=%b lat=%0d",
               quotient, remainder, div_by_zero, lat);
      tests_run++;
      if (lat !== 0) begin
         tests_failed++;
         $display("FAIL dbz_latency: got %0d required 0", lat);
      end
      tests_run++;
      if (quotient !== ONES || remainder !== 64'h1234 || div_by_zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL dbz_result: q=%h r=%h dbz=%b required all-ones 1234 1",
                  quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || div_by_zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL dbz_hold: done=%b dbz=%b required 0 1", done, div_by_zero);
      end
      run_op(64'd10, 64'd3, lat);
      $display("[TB] 10/3 -> q=%0d r=%0d dbz=%b lat=%0d",
               quotient, remainder, div_by_zero, lat);
      tests_run++;
      if (lat !== W || quotient !== 64'd3 || remainder !== 64'd1 || div_by_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL dbz_clear: lat=%0d q=%0d r=%0d dbz=%b required %0d 3 1 0",
                  lat, quotient, remainder, div_by_zero, W);
      end
   endtask

   task automatic test_boundary;
      logic [W-1:0] va [6];
      logic [W-1:0] vb [6];
      logic [W-1:0] vq [6];
      logic [W-1:0] vr [6];
      int lat;
      va[0] = ONES;           vb[0] = 64'd1;  vq[0] = ONES;           vr[0] = 64'd0;
      va[1] = 64'd5;          vb[1] = ONES;   vq[1] = 64'd0;          vr[1] = 64'd5;
      va[2] = 64'd0;          vb[2] = 64'd9;  vq[2] = 64'd0;          vr[2] = 64'd0;
      va[3] = ONES;           vb[3] = ONES;   vq[3] = 64'd1;          vr[3] = 64'd0;
      va[4] = ONES;           vb[4] = 64'd2;  vq[4] = 64'h7FFF_FFFF_FFFF_FFFF; vr[4] = 64'd1;
      va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'd3;
      vq[5] = 64'd3074457345618258602; vr[5] = 64'd2;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], lat);
         $display("[TB] boundary %0d: %h/%h -> q=%h r=%h lat=%0d",
                  i, va[i], vb[i], quotient, remainder, lat);
         tests_run++;
         if (lat !== W || quotient !== vq[i] || remainder !== vr[i]) begin
            tests_failed++;
            $display("FAIL boundary_%0d: lat=%0d q=%h r=%h required %0d %h %h",
                     i, lat, quotient, remainder, W, vq[i], vr[i]);
         end
      end
   endtask

   task automatic test_start_while_busy;
      int lat;
      @(negedge clk);
      start = 1'b1; dividend = 64'd50; divisor = 64'd5;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      // This negedge is RUN cycle 1; step forward to cycle 10.
      repeat (9) begin
         @(negedge clk);
         lat++;
      end
      start = 1'b1; dividend = 64'd99; divisor = 64'd2;
      @(negedge clk);
      lat++;
      start = 1'b0;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      $display("[TB] 50/5 with ignored start -> q=%0d r=%0d lat=%0d",
               quotient, remainder, lat);
      tests_run++;
      if (done !== 1'b1 || lat !== W || quotient !== 64'd10 || remainder !== 64'd0) begin
         tests_failed++;
         $display("FAIL busy_ignore: done=%b lat=%0d q=%0d r=%0d required 1 %0d 10 0",
                  done, lat, quotient, remainder, W);
      end
      // The ignored request must not have been queued.
      repeat (2) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL busy_no_queue: busy=%b required 0", busy);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      int lat2;
      @(negedge clk);
      start = 1'b1; dividend = 64'd1000; divisor = 64'd7;
      @(negedge clk);
      n = 0;
      // Operands change while RUN; start stays high throughout.
      dividend = 64'd77; divisor = 64'd8;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      $display("[TB] b2b op1 1000/7 -> q=%0d r=%0d lat=%0d", quotient, remainder, n);
      tests_run++;
      if (n !== W || quotient !== 64'd142 || remainder !== 64'd6) begin
         tests_failed++;
         $display("FAIL b2b_first: lat=%0d q=%0d r=%0d required %0d 142 6",
                  n, quotient, remainder, W);
      end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle_gap: busy=%b required 0", busy);
      end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_accept: busy=%b done=%b required 1 0 (interval %0d)",
                  busy, done, W + 2);
      end
      start = 1'b0;
      lat2 = 0;
      while (done !== 1'b1 && lat2 < 200) begin
         @(negedge clk);
         lat2++;
      end
      $display("[TB] b2b op2 77/8 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat2);
      tests_run++;
      if (lat2 !== W || quotient !== 64'd9 || remainder !== 64'd5) begin
         tests_failed++;
         $display("FAIL b2b_second: lat=%0d q=%0d r=%0d required %0d 9 5",
                  lat2, quotient, remainder, W);
      end
   endtask

   task automatic test_reset_mid_run;
      int lat;
      bit saw_done;
      // Leave div_by_zero and quotient nonzero beforehand.
      run_op(64'h55, 64'd0, lat);
      @(negedge clk);
      start = 1'b1; dividend = 64'hDEAD_BEEF_0123_4567; divisor = 64'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
         tests_failed++;
         $display("FAIL midrun_reset: busy/done/dbz=%b q=%h r=%h required 000 0 0",
                  {busy, done, div_by_zero}, quotient, remainder);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      tests_run++;
      if (saw_done) begin
         tests_failed++;
         $display("FAIL midrun_no_done: done/busy seen=1 required 0");
      end
      run_op(64'd17, 64'd4, lat);
      $display("[TB] after reset 17/4 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
      tests_run++;
      if (lat !== W || quotient !== 64'd4 || remainder !== 64'd1) begin
         tests_failed++;
         $display("FAIL midrun_recover: lat=%0d q=%0d r=%0d required %0d 4 1",
                  lat, quotient, remainder, W);
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      int lat;
      for (int i = 0; i < 1000; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom} >> $urandom_range(0, 63);
         if (b == '0) b = 64'd1;
         eq = a / b;
         er = a % b;
         run_op(a, b, lat);
         $display("[TB] rnd %0d: %h/%h -> q=%h r=%h lat=%0d",
                  i, a, b, quotient, remainder, lat);
         tests_run++;
         if (lat !== W || quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_%0d: lat=%0d q=%h r=%h dbz=%b required %0d %h %h 0",
                     i, lat, quotient, remainder, div_by_zero, W, eq, er);
         end
      end
   endtask

   initial begin
      test_reset;
      test_normal;
      test_div_by_zero;
      test_boundary;
      test_start_while_busy;
      test_back_to_back;
      test_reset_mid_run;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned integer divider for the datapath, built from a single shared subtractor. It is the inverse of the adder/subtractor chain: it repeatedly subtracts to recover quotient and remainder instead of summing. It sits beside the ALU and is started by the execute stage for divide instructions. It produces `quotient` and `remainder` after `WIDTH` iterations using a restoring shift-subtract algorithm.

## Interface
- `WIDTH`, default 64: operand and result width in bits (≥2).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  unsigned numerator; sampled with `start`.
- `divisor`  in  WIDTH  unsigned denominator; sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse (high exactly while in DONE).
- `quotient`  out  WIDTH  result register.
- `remainder`  out  WIDTH  result register.
- `div_by_zero`  out  1  set when the last accepted divisor was 0.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** asynchronous and active-high. It forces IDLE and clears every output and internal register to 0: `busy=0`, `done=0`, `quotient=0`, `remainder=0`, `div_by_zero=0`, iteration counter 0.
- **IDLE, `start=1`, divisor≠0:**
  - Load `quotient←dividend`, `remainder←0`, store `divisor`.
  - Set counter to `WIDTH`, clear `div_by_zero`, go to RUN.
- **IDLE, `start=1`, divisor=0:**
  - Load `quotient←{WIDTH{1}}`, `remainder←dividend`, set `div_by_zero=1`.
  - Go directly to DONE; no iterations run.
- **RUN, each cycle:**
  - Form `{r,q} = {remainder,quotient} << 1`.
  - Compute trial `t = r − divisor` at WIDTH+1 bits so the borrow is explicit.
  - No borrow: `remainder←t[WIDTH-1:0]`, `quotient←q|1`.
  - Borrow: `remainder←r`, `quotient←q`.
  - Decrement the counter. When the counter reaches 0 on this edge, go to DONE.
- **DONE:** `done=1` for one cycle, then unconditionally go to IDLE.
- **Result hold:** `quotient`, `remainder` and `div_by_zero` hold their values in IDLE until the next accepted `start`.
- **Ignored `start`:** `start` in RUN or DONE is ignored. It is neither queued nor does it disturb the operation. Operand changes during RUN have no effect.
- **Width rule:** the intermediate shifted remainder needs WIDTH+1 bits. The final remainder is always < divisor and fits in WIDTH bits.

## Timing
- **Normal latency:** `start` sampled at edge E0. Iterations occur on edges E1…E`WIDTH`. State is DONE after edge E`WIDTH`, so `done` is high in the cycle following E`WIDTH`. Results are valid in that same cycle.
- **Divide-by-zero latency:** `done` is high in the cycle after E0.
- **`busy`:** rises after E0 and falls with `done`. The back-to-back start is therefore accepted at the edge after the DONE cycle, giving a minimum issue interval of `WIDTH`+2 edges.
- **Reset mid-RUN:** the operation is aborted immediately without waiting for a clock edge, with no `done` pulse. After reset release the block accepts `start` on the next edge.
- **Glitch-free outputs:** `done` and `busy` are decoded from the registered state only, with no combinational path from `start`.

## Test plan
- **Normal divide:** WIDTH=64, `dividend=100`, `divisor=7`, `start` for 1 cycle → `done` exactly 64 cycles after the sampling edge; `quotient=14`, `remainder=2`, `div_by_zero=0`, one-cycle `done` pulse.
- **Divide by zero:** `dividend=0x1234`, `divisor=0` → `done` the cycle after `start`; `quotient=0xFFFF_FFFF_FFFF_FFFF`, `remainder=0x1234`, `div_by_zero=1`. A following divide of 10/3 → `div_by_zero=0`, `quotient=3`, `remainder=1`.
- **Boundary operands:**
  - `dividend=0xFFFF_FFFF_FFFF_FFFF`, `divisor=1` → `quotient=all ones`, `remainder=0`.
  - `divisor=0xFFFF_FFFF_FFFF_FFFF`, `dividend=5` → `quotient=0`, `remainder=5`.
  - `dividend=0`, `divisor=9` → `0`, `0`.
- **Start while busy:** start 50/5; assert `start` with 99/2 at cycle 10 of RUN → ignored; result `quotient=10`, `remainder=0`. Holding `start` high continuously → the next op is accepted the edge after DONE.
- **Reset mid-operation:** assert `reset` asynchronously (not on an edge) at cycle 30 of RUN → all outputs 0 immediately, no `done` pulse. After release, 17/4 → `quotient=4`, `remainder=1` at normal latency.
- **Random sweep:** 1000 random operand pairs with nonzero divisor, checked against the model `q=a/b`, `r=a%b` and the exact `done` cycle count.
